// File: rtl/hap_pkg.sv
// Shared definitions for the Harvard processor front end: widths, reset PC,
// fetch FSM state encodings and the branch/jump opcodes.
package hap_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t RESET_PC = 8'h00;

  // Fetch FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Branch/jump opcodes (upper nibble of an instruction)
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_BE   = 4'h9;
  localparam logic [3:0] OP_BNER = 4'hA;
  localparam logic [3:0] OP_BER  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;

  // PC increment; wraps modulo 2^ADDR_W with no overflow indication
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + 8'h01;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
  import hap_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_ack;
  instr_t imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over the imem bus,
// holds each instruction with its next-PC until consumed, and honours
// branch redirects by discarding stale or in-flight fetches.
module fetch_unit
  import hap_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  output instr_t              instr,
  output logic                instr_valid,
  output addr_t               npc,
  input  logic                instr_ready,
  input  logic                redirect,
  input  addr_t               redirect_pc
);

  logic [1:0] state_q, state_d;
  addr_t      pc_q,    pc_d;
  logic       kill_q,  kill_d;
  logic       req_q,   req_d;
  addr_t      addr_q,  addr_d;
  instr_t     instr_q, instr_d;
  logic       valid_q, valid_d;
  addr_t      npc_q,   npc_d;

  // Next-state and next-output logic for the fetch FSM
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    npc_d   = npc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      FETCH: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            // Returned word belongs to the old path; refetch at the target
            pc_d   = redirect_pc;
            kill_d = 1'b0;
            req_d  = 1'b1;
            addr_d = redirect_pc;
          end else if (kill_q) begin
            // Completes a request made stale by an earlier redirect
            kill_d = 1'b0;
            req_d  = 1'b1;
            addr_d = pc_q;
          end else begin
            instr_d = imem.imem_data;
            npc_d   = pc_inc(pc_q);
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (redirect) begin
          // Request must stay stable mid-handshake: remember the target
          // and mark the outstanding fetch for discard
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_inc(pc_q);
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_inc(pc_q);
          state_d = FETCH;
        end else begin
          valid_d = valid_q;
        end
      end

      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
      npc_q   <= pc_inc(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      npc_q   <= npc_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign npc            = npc_q;

endmodule
